// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with req/ack data-memory handshake and timeout fault.
// Optional performance counters enabled by defining MEM_PERF_CNT_EN.
module mem_stage #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [31:0]       ex_result,
   input  logic [2:0]        ex_flag,
   input  logic [31:0]       ex_next_pc,
   input  logic [31:0]       ex_store_data,
   input  logic [4:0]        ex_rd,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [4:0]        wb_rd,
   output logic [2:0]        wb_flag,
   output logic [31:0]       wb_next_pc,
   output logic              mem_fault
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]       perf_loads,
   output logic [31:0]       perf_stores,
   output logic [31:0]       perf_stall_cycles
`endif
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_d;
   logic [31:0] res_q, pc_q, sd_q, data_q, data_d;
   logic [2:0]  flag_q;
   logic [4:0]  rd_q;
   logic        we_q, fault_q, fault_d;
   logic [7:0]  cnt, cnt_d;
   always_comb begin
      state_d = state;
      data_d  = data_q;
      fault_d = fault_q;
      cnt_d   = cnt;
      case (state)
         IDLE: if (ex_valid) begin
            state_d = (mem_read ^ mem_write) ? ACCESS : DONE;
            data_d  = (mem_read | mem_write) ? 32'h0 : ex_result;
            fault_d = mem_read & mem_write;
            cnt_d   = 8'h0;
         end
         ACCESS: begin
            cnt_d = cnt + 8'h1;
            // an ack in the timeout cycle still wins
            if (dmem_ack) begin
               state_d = DONE;
               data_d  = we_q ? res_q : dmem_rdata;
               fault_d = 1'b0;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               state_d = DONE;
               data_d  = 32'h0;
               fault_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 8'h0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         res_q   <= '0;
         pc_q    <= '0;
         sd_q    <= '0;
         flag_q  <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         fault_q <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_d;
         data_q  <= data_d;
         fault_q <= fault_d;
         cnt     <= cnt_d;
         if (state == IDLE && ex_valid) begin
            res_q  <= ex_result;
            pc_q   <= ex_next_pc;
            sd_q   <= ex_store_data;
            flag_q <= ex_flag;
            rd_q   <= ex_rd;
            we_q   <= mem_write;
         end
      end
   end
   assign stall      = state != IDLE;
   assign dmem_req   = state == ACCESS;
   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = res_q[ADDR_W-1:0];
   assign dmem_wdata = sd_q;
   assign wb_valid   = state == DONE;
   assign wb_data    = data_q;
   assign wb_rd      = rd_q;
   assign wb_flag    = flag_q;
   assign wb_next_pc = pc_q;
   assign mem_fault  = wb_valid & fault_q;
`ifdef MEM_PERF_CNT_EN
   logic done_ok;
   assign done_ok = dmem_req & dmem_ack;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_loads        <= '0;
         perf_stores       <= '0;
         perf_stall_cycles <= '0;
      end else begin
         perf_loads        <= perf_loads + 32'(done_ok && !we_q && perf_loads != '1);
         perf_stores       <= perf_stores + 32'(done_ok && we_q && perf_stores != '1);
         perf_stall_cycles <= perf_stall_cycles + 32'(stall && perf_stall_cycles != '1);
      end
   end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven bench with a write-back scoreboard for mem_stage (TIMEOUT=4).
module tb_mem_stage;
   logic clk = 1'b0, reset = 1'b0;
   logic ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, dmem_ack = 1'b0;
   logic [31:0] ex_result = '0, ex_next_pc = '0, ex_store_data = '0, dmem_rdata = '0;
   logic [2:0]  ex_flag = '0;
   logic [4:0]  ex_rd = '0;
   logic stall, dmem_req, dmem_we, wb_valid, mem_fault;
   logic [15:0] dmem_addr;
   logic [31:0] dmem_wdata, wb_data, wb_next_pc;
   logic [4:0]  wb_rd;
   logic [2:0]  wb_flag;
   int chk_cnt = 0, pass_cnt = 0, wb_seen = 0, exp_loads = 0, exp_stores = 0, stall_tally = 0;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

   mem_stage #(.ADDR_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result), .ex_flag(ex_flag),
      .ex_next_pc(ex_next_pc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .mem_read(mem_read), .mem_write(mem_write), .stall(stall), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_flag(wb_flag), .wb_next_pc(wb_next_pc), .mem_fault(mem_fault)
`ifdef MEM_PERF_CNT_EN
      , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res; logic [2:0] flag; logic [31:0] pc; logic [31:0] sd; logic [4:0] rd;
      logic rd_en; logic wr_en; int dly; logic [31:0] rdata;
      logic [31:0] exp_data; logic exp_fault; int exp_req;
   } vec_t;
   typedef struct { logic [31:0] data; logic [4:0] rd; logic [2:0] flag; logic [31:0] pc; logic fault; } exp_t;
   exp_t q[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
      else pass_cnt++;
   endtask

   always @(negedge clk) if (wb_valid) begin
      exp_t e;
      wb_seen++;
      if (q.size() == 0) chk("unexpected_wb", 1, 0);
      else begin
         e = q.pop_front();
         chk("wb_data", wb_data, e.data);
         chk("wb_rd", 32'(wb_rd), 32'(e.rd));
         chk("wb_flag", 32'(wb_flag), 32'(e.flag));
         chk("wb_next_pc", wb_next_pc, e.pc);
         chk("mem_fault", 32'(mem_fault), 32'(e.fault));
      end
   end

   always @(posedge clk or negedge reset)
      if (!reset) stall_tally <= 0;
      else if (stall) stall_tally <= stall_tally + 1;

   task automatic apply(input vec_t v);
      int cyc, nreq;
      @(negedge clk);
      ex_valid = 1'b1; ex_result = v.res; ex_flag = v.flag; ex_next_pc = v.pc;
      ex_store_data = v.sd; ex_rd = v.rd; mem_read = v.rd_en; mem_write = v.wr_en;
      q.push_back('{v.exp_data, v.rd, v.flag, v.pc, v.exp_fault});
      if (v.dly >= 0 && v.rd_en && !v.wr_en) exp_loads++;
      if (v.dly >= 0 && v.wr_en && !v.rd_en) exp_stores++;
      @(negedge clk);
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      cyc = 0; nreq = 0;
      while (!wb_valid && cyc < 20) begin
         chk("stall_busy", 32'(stall), 1);
         if (dmem_req) begin
            nreq++;
            if (nreq == 1) begin
               chk("dmem_addr", 32'(dmem_addr), {16'h0, v.res[15:0]});
               chk("dmem_we", 32'(dmem_we), 32'(v.wr_en));
               chk("dmem_wdata", dmem_wdata, v.sd);
            end
            dmem_ack = (v.dly >= 0 && nreq == v.dly + 1);
            dmem_rdata = v.rdata;
         end
         @(negedge clk);
         dmem_ack = 1'b0;
         cyc++;
      end
      if (cyc == 20) chk("wb_wait_timeout", 32'(cyc), 0);
      chk("req_cycles", 32'(nreq), 32'(v.exp_req));
      @(negedge clk);
      chk("wb_pulse_end", 32'(wb_valid), 0);
      chk("stall_release", 32'(stall), 0);
   endtask

   vec_t vecs[7];
   int s;

   initial begin
      vecs[0] = '{32'h0000_1234, 3'd2, 32'h100, 32'h0, 5'd5, 1'b0, 1'b0, -1, 32'h0, 32'h0000_1234, 1'b0, 0};
      vecs[1] = '{32'h0000_0040, 3'd1, 32'h104, 32'h0, 5'd7, 1'b1, 1'b0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
      vecs[2] = '{32'h0000_0080, 3'd4, 32'h108, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1, 32'h0, 32'h0000_0080, 1'b0, 2};
      vecs[3] = '{32'h0000_0044, 3'd3, 32'h10C, 32'h0, 5'd9, 1'b1, 1'b0, -1, 32'h0, 32'h0, 1'b1, 4};
      vecs[4] = '{32'h0000_0099, 3'd6, 32'h110, 32'h5, 5'd10, 1'b1, 1'b1, -1, 32'h0, 32'h0, 1'b1, 0};
      vecs[5] = '{32'hFFFF_0123, 3'd7, 32'h114, 32'h0, 5'd12, 1'b1, 1'b0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
      vecs[6] = '{32'hFFFF_FFFF, 3'd5, 32'h118, 32'h0, 5'd31, 1'b0, 1'b0, -1, 32'h0, 32'hFFFF_FFFF, 1'b0, 0};

      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_we", 32'(dmem_we), 0);
      chk("rst_addr", 32'(dmem_addr), 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", 32'(wb_rd), 0);
      chk("rst_wb_flag", 32'(wb_flag), 0);
      chk("rst_wb_pc", wb_next_pc, 0);
      chk("rst_fault", 32'(mem_fault), 0);
      #1 reset = 1'b1;

      // reset during ACCESS discards the op
      @(negedge clk);
      ex_valid = 1'b1; ex_result = 32'h60; mem_read = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0; mem_read = 1'b0;
      chk("req_before_rst", 32'(dmem_req), 1);
      #2 reset = 1'b0;
      #1 chk("req_async_drop", 32'(dmem_req), 0);
      chk("stall_async_drop", 32'(stall), 0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      s = wb_seen;
      repeat (5) @(negedge clk);
      chk("no_wb_after_rst", 32'(wb_seen), 32'(s));

      for (int i = 0; i < 7; i++) apply(vecs[i]);

      // ex_valid held while stalled must be ignored
      s = wb_seen;
      @(negedge clk);
      ex_valid = 1'b1; ex_result = 32'h55; ex_rd = 5'd3; ex_flag = 3'd1; ex_next_pc = 32'h4;
      q.push_back('{32'h55, 5'd3, 3'd1, 32'h4, 1'b0});
      @(negedge clk);
      chk("b2b_stall", 32'(stall), 1);
      ex_result = 32'h66; ex_rd = 5'd4;
      @(negedge clk);
      ex_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_one_wb", 32'(wb_seen), 32'(s + 1));

      // stray ack while idle
      s = wb_seen;
      dmem_ack = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ack_req", 32'(dmem_req), 0);
      dmem_ack = 1'b0;
      chk("idle_ack_no_wb", 32'(wb_seen), 32'(s));
      chk("scoreboard_empty", 32'(q.size()), 0);

`ifdef MEM_PERF_CNT_EN
      chk("perf_loads", perf_loads, 32'(exp_loads));
      chk("perf_stores", perf_stores, 32'(exp_stores));
      chk("perf_stall", perf_stall_cycles, 32'(stall_tally));
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
